// File: rtl/mux_arb_nxw_if.sv
// Handshake bundle for mux_arb_nxw: N producer channels in, one registered
// consumer channel out.
interface mux_arb_nxw_if #(
   parameter int WIDTH = 32,
   parameter int N     = 4
);
   localparam int SELW = $clog2(N);

   logic [N-1:0]       in_valid;
   logic [N*WIDTH-1:0] in_data;
   logic [N-1:0]       in_ready;
   logic               out_valid;
   logic [WIDTH-1:0]   out_data;
   logic [SELW-1:0]    out_src;
   logic               out_ready;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_src
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_src
   );
endinterface

// File: rtl/mux_arb_nxw.sv
// N-channel registered selector: steered by sel (mode 0) or round-robin
// arbitrated (mode 1), with valid/ready handshake on every channel.
module mux_arb_nxw #(
   parameter  int WIDTH = 32,
   parameter  int N     = 4,
   localparam int SELW  = $clog2(N)
) (
   input  logic            clk,
   input  logic            clrn,
   input  logic            mode,
   input  logic [SELW-1:0] sel,
   mux_arb_nxw_if.slave    bus
);

   logic [SELW-1:0]  rr_ptr;
   logic [SELW-1:0]  grant;
   logic             granted;
   logic             load;
   logic [WIDTH-1:0] word;

   // Output register may refill in the same cycle it drains.
   assign load = !bus.out_valid || bus.out_ready;

   always_comb begin
      grant   = '0;
      granted = 1'b0;
      if (!mode) begin
         for (int unsigned i = 0; i < N; i++) begin
            if (!granted && bus.in_valid[i] && sel == SELW'(i)) begin
               grant   = SELW'(i);
               granted = 1'b1;
            end
         end
      end else begin
         // First pass covers rr_ptr..N-1, second pass wraps to 0..rr_ptr-1.
         for (int unsigned i = 0; i < N; i++) begin
            if (!granted && bus.in_valid[i] && SELW'(i) >= rr_ptr) begin
               grant   = SELW'(i);
               granted = 1'b1;
            end
         end
         for (int unsigned i = 0; i < N; i++) begin
            if (!granted && bus.in_valid[i]) begin
               grant   = SELW'(i);
               granted = 1'b1;
            end
         end
      end
   end

   always_comb begin
      word         = '0;
      bus.in_ready = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (grant == SELW'(i)) begin
            word = bus.in_data[i*WIDTH +: WIDTH];
            bus.in_ready[i] = clrn && load && granted;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!clrn) begin
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         bus.out_src   <= '0;
         rr_ptr        <= '0;
      end else if (load) begin
         if (granted) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= word;
            bus.out_src   <= grant;
            rr_ptr        <= (grant == SELW'(N-1)) ? '0 : grant + 1'b1;
         end else begin
            bus.out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mux_arb_nxw.sv
// Scoreboard bench for mux_arb_nxw: a 4x32 instance and a 3x32 instance
// driven by directed vectors with hand-computed expected words.
module tb_mux_arb_nxw;

   logic       clk = 1'b0;
   logic       clrn;
   logic       mode4, mode3;
   logic [1:0] sel4, sel3;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   logic [33:0] q4[$];
   logic [33:0] q3[$];

   mux_arb_nxw_if #(.WIDTH(32), .N(4)) bus4 ();
   mux_arb_nxw_if #(.WIDTH(32), .N(3)) bus3 ();

   mux_arb_nxw #(.WIDTH(32), .N(4)) dut4 (
      .clk(clk), .clrn(clrn), .mode(mode4), .sel(sel4), .bus(bus4.slave)
   );
   mux_arb_nxw #(.WIDTH(32), .N(3)) dut3 (
      .clk(clk), .clrn(clrn), .mode(mode3), .sel(sel3), .bus(bus3.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitors pop an expected word whenever a delivery happens on the next edge.
   always @(negedge clk) begin
      if (clrn && bus4.out_valid && bus4.out_ready) begin
         if (q4.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL out4_unexpected: got %h src %0d expected nothing", bus4.out_data, bus4.out_src);
         end else begin
            logic [33:0] e;
            e = q4.pop_front();
            chk("out4_data", bus4.out_data, e[33:2]);
            chk("out4_src", {30'b0, bus4.out_src}, {30'b0, e[1:0]});
         end
      end
   end

   always @(negedge clk) begin
      if (clrn && bus3.out_valid && bus3.out_ready) begin
         if (q3.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL out3_unexpected: got %h src %0d expected nothing", bus3.out_data, bus3.out_src);
         end else begin
            logic [33:0] e;
            e = q3.pop_front();
            chk("out3_data", bus3.out_data, e[33:2]);
            chk("out3_src", {30'b0, bus3.out_src}, {30'b0, e[1:0]});
         end
      end
   end

   task automatic step4(input logic [3:0] v, input logic m, input logic [1:0] s, input logic rdy,
                        input logic [3:0] er, input logic push, input logic [31:0] ed, input logic [1:0] es);
      bus4.in_valid  = v;
      mode4          = m;
      sel4           = s;
      bus4.out_ready = rdy;
      @(negedge clk);
      chk("in_ready4", {28'b0, bus4.in_ready}, {28'b0, er});
      if (push) q4.push_back({ed, es});
      @(posedge clk); #1;
   endtask

   task automatic step3(input logic [2:0] v, input logic m, input logic [1:0] s, input logic rdy,
                        input logic [2:0] er, input logic push, input logic [31:0] ed, input logic [1:0] es);
      bus3.in_valid  = v;
      mode3          = m;
      sel3           = s;
      bus3.out_ready = rdy;
      @(negedge clk);
      chk("in_ready3", {29'b0, bus3.in_ready}, {29'b0, er});
      if (push) q3.push_back({ed, es});
      @(posedge clk); #1;
   endtask

   initial begin
      clrn           = 1'b0;
      bus4.in_data   = {32'h44444444, 32'hDEADBEEF, 32'h22222222, 32'h11111111};
      bus3.in_data   = {32'hCCCC2222, 32'hBBBB1111, 32'hAAAA0000};
      bus3.in_valid  = '0;
      bus3.out_ready = 1'b1;
      mode3          = 1'b0;
      sel3           = '0;

      // Reset held for two edges with every channel offering.
      step4(4'b1111, 1'b1, 2'd0, 1'b1, 4'b0000, 1'b0, '0, '0);
      step4(4'b1111, 1'b1, 2'd0, 1'b1, 4'b0000, 1'b0, '0, '0);
      chk("rst_out_valid", {31'b0, bus4.out_valid}, 32'd0);
      chk("rst_out_data", bus4.out_data, 32'd0);
      chk("rst_out_src", {30'b0, bus4.out_src}, 32'd0);
      clrn = 1'b1;

      // Round-robin, all valid: 0,1,2,3,0,1,2,3.
      for (int k = 0; k < 2; k++) begin
         step4(4'b1111, 1'b1, 2'd0, 1'b1, 4'b0001, 1'b1, 32'h11111111, 2'd0);
         step4(4'b1111, 1'b1, 2'd0, 1'b1, 4'b0010, 1'b1, 32'h22222222, 2'd1);
         step4(4'b1111, 1'b1, 2'd0, 1'b1, 4'b0100, 1'b1, 32'hDEADBEEF, 2'd2);
         step4(4'b1111, 1'b1, 2'd0, 1'b1, 4'b1000, 1'b1, 32'h44444444, 2'd3);
      end
      // Sparse valids 1010: 1,3,1,3.
      for (int k = 0; k < 2; k++) begin
         step4(4'b1010, 1'b1, 2'd0, 1'b1, 4'b0010, 1'b1, 32'h22222222, 2'd1);
         step4(4'b1010, 1'b1, 2'd0, 1'b1, 4'b1000, 1'b1, 32'h44444444, 2'd3);
      end

      // Steered select, then a select on an idle channel.
      step4(4'b1111, 1'b0, 2'd2, 1'b1, 4'b0100, 1'b1, 32'hDEADBEEF, 2'd2);
      step4(4'b0111, 1'b0, 2'd3, 1'b1, 4'b0000, 1'b0, '0, '0);
      chk("steer_idle_valid", {31'b0, bus4.out_valid}, 32'd0);

      // Back-pressure: hold for three cycles, then drain and refill together.
      step4(4'b1111, 1'b0, 2'd1, 1'b1, 4'b0010, 1'b1, 32'h22222222, 2'd1);
      for (int k = 0; k < 3; k++) begin
         step4(4'b1111, 1'b0, 2'd1, 1'b0, 4'b0000, 1'b0, '0, '0);
         chk("bp_hold_data", bus4.out_data, 32'h22222222);
         chk("bp_hold_valid", {31'b0, bus4.out_valid}, 32'd1);
      end
      step4(4'b1111, 1'b0, 2'd3, 1'b1, 4'b1000, 1'b1, 32'h44444444, 2'd3);
      chk("no_bubble_valid", {31'b0, bus4.out_valid}, 32'd1);
      step4(4'b0000, 1'b1, 2'd0, 1'b1, 4'b0000, 1'b0, '0, '0);

      // Mid-operation reset discards the held word and rewinds rr_ptr.
      bus4.in_data[31:0] = 32'h12345678;
      step4(4'b0001, 1'b0, 2'd0, 1'b1, 4'b0001, 1'b0, '0, '0);
      step4(4'b0000, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0, '0, '0);
      chk("held_word", bus4.out_data, 32'h12345678);
      clrn = 1'b0;
      step4(4'b0000, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0, '0, '0);
      clrn = 1'b1;
      chk("midrst_valid", {31'b0, bus4.out_valid}, 32'd0);
      chk("midrst_data", bus4.out_data, 32'd0);
      step4(4'b1111, 1'b1, 2'd0, 1'b1, 4'b0001, 1'b1, 32'h12345678, 2'd0);
      step4(4'b0000, 1'b1, 2'd0, 1'b1, 4'b0000, 1'b0, '0, '0);

      // N=3: out-of-range select never grants; round-robin from rr_ptr=2.
      step3(3'b111, 1'b0, 2'd3, 1'b1, 3'b000, 1'b0, '0, '0);
      chk("n3_sel3_valid", {31'b0, bus3.out_valid}, 32'd0);
      step3(3'b111, 1'b0, 2'd1, 1'b1, 3'b010, 1'b1, 32'hBBBB1111, 2'd1);
      step3(3'b111, 1'b1, 2'd0, 1'b1, 3'b100, 1'b1, 32'hCCCC2222, 2'd2);
      step3(3'b111, 1'b1, 2'd0, 1'b1, 3'b001, 1'b1, 32'hAAAA0000, 2'd0);
      step3(3'b000, 1'b1, 2'd0, 1'b1, 3'b000, 1'b0, '0, '0);
      step3(3'b000, 1'b1, 2'd0, 1'b1, 3'b000, 1'b0, '0, '0);

      chk("q4_drained", q4.size(), 32'd0);
      chk("q3_drained", q3.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
